// File: rtl/ldpc_bitflip_decode.sv
// Hard-decision Gallager bit-flipping LDPC decoder, one check/flip pair per iteration.
// Define LDPC_DEC_EARLY_EXIT_EN to stop as soon as the syndrome clears (variable latency).
module ldpc_bitflip_decode #(
    parameter int N        = 6,
    parameter int K        = 3,
    parameter int MAX_ITER = 8
) (
    input  logic                            clk,
    input  logic                            i_rst_n,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [N-1:0]                    i_word,
    input  logic [(N-K)*N-1:0]              i_h,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [N-1:0]                    o_word,
    output logic [K-1:0]                    o_info,
    output logic                            o_success,
    output logic [$clog2(MAX_ITER+1)-1:0]   o_iter
);

    localparam int M  = N - K;
    localparam int IW = $clog2(MAX_ITER + 1);
    localparam int CW = $clog2(M + 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        FLIP,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [N-1:0]    w_q;
    logic [M*N-1:0]  h_q;
    logic [M-1:0]    s_q;
    logic [M-1:0]    s_c;
    logic [IW-1:0]   iter_q;
    logic            success_q;
    logic [CW-1:0]   cnt [N];
    logic [CW-1:0]   cnt_max;
    logic [N-1:0]    flip_mask;
    logic            at_limit;
    logic            s_zero;
    logic            go_done;

    always_comb begin
        s_c = '0;
        for (int r = 0; r < M; r++) begin
            s_c[r] = ^(h_q[r*N +: N] & w_q);
        end
    end

    // Unsatisfied-check votes per bit; every bit sharing the top vote flips.
    always_comb begin
        cnt_max   = '0;
        flip_mask = '0;
        for (int c = 0; c < N; c++) begin
            cnt[c] = '0;
            for (int r = 0; r < M; r++) begin
                cnt[c] = cnt[c] + CW'(s_q[r] & h_q[r*N+c]);
            end
        end
        for (int c = 0; c < N; c++) begin
            if (cnt[c] > cnt_max) begin
                cnt_max = cnt[c];
            end
        end
        for (int c = 0; c < N; c++) begin
            flip_mask[c] = (cnt[c] == cnt_max) && (cnt_max != '0);
        end
    end

    assign at_limit = (iter_q == IW'(MAX_ITER));
    assign s_zero   = (s_c == '0);

`ifdef LDPC_DEC_EARLY_EXIT_EN
    assign go_done = s_zero || at_limit;
`else
    assign go_done = at_limit;
`endif

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = go_done ? DONE : FLIP;
            end
            FLIP: begin
                state_d = CHECK;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            w_q       <= '0;
            h_q       <= '0;
            s_q       <= '0;
            iter_q    <= '0;
            success_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        w_q       <= i_word;
                        h_q       <= i_h;
                        s_q       <= '0;
                        iter_q    <= '0;
                        success_q <= 1'b0;
                    end
                end
                CHECK: begin
                    s_q <= s_c;
                    if (go_done) begin
                        success_q <= s_zero;
                    end
                end
                FLIP: begin
                    w_q    <= w_q ^ flip_mask;
                    iter_q <= iter_q + IW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign o_word    = w_q;
    assign o_info    = w_q[N-1:N-K];
    assign o_success = success_q;
    assign o_iter    = iter_q;

endmodule

// File: tb/tb_ldpc_bitflip_decode.sv
// Directed bench for ldpc_bitflip_decode: decode cases, iteration limit,
// DONE hold/handshake and mid-iteration reset, for either macro setting.
module tb_ldpc_bitflip_decode;

    localparam logic [17:0] HMAT = 18'h346A9;

`ifdef LDPC_DEC_EARLY_EXIT_EN
    localparam int LAT_CLEAN  = 1;
    localparam int LAT_ONE    = 3;
    localparam int LAT_TIE    = 5;
    localparam int IT_CLEAN   = 0;
    localparam int IT_ONE     = 1;
    localparam int IT_TIE     = 2;
`else
    localparam int LAT_CLEAN  = 17;
    localparam int LAT_ONE    = 17;
    localparam int LAT_TIE    = 17;
    localparam int IT_CLEAN   = 8;
    localparam int IT_ONE     = 8;
    localparam int IT_TIE     = 8;
`endif

    logic        clk;
    logic        rst_n;
    logic        valid0;
    logic        valid1;
    logic [5:0]  word;
    logic [17:0] h;
    logic        rdy;

    logic        o_ready0;
    logic        o_valid0;
    logic [5:0]  o_word0;
    logic [2:0]  o_info0;
    logic        o_success0;
    logic [3:0]  o_iter0;

    logic        o_ready1;
    logic        o_valid1;
    logic [5:0]  o_word1;
    logic [2:0]  o_info1;
    logic        o_success1;
    logic [0:0]  o_iter1;

    int checks;
    int errors;

    ldpc_bitflip_decode #(.N(6), .K(3), .MAX_ITER(8)) dut0 (
        .clk       (clk),
        .i_rst_n   (rst_n),
        .i_valid   (valid0),
        .o_ready   (o_ready0),
        .i_word    (word),
        .i_h       (h),
        .o_valid   (o_valid0),
        .i_ready   (rdy),
        .o_word    (o_word0),
        .o_info    (o_info0),
        .o_success (o_success0),
        .o_iter    (o_iter0)
    );

    ldpc_bitflip_decode #(.N(6), .K(3), .MAX_ITER(1)) dut1 (
        .clk       (clk),
        .i_rst_n   (rst_n),
        .i_valid   (valid1),
        .o_ready   (o_ready1),
        .i_word    (word),
        .i_h       (h),
        .o_valid   (o_valid1),
        .i_ready   (rdy),
        .o_word    (o_word1),
        .o_info    (o_info1),
        .o_success (o_success1),
        .o_iter    (o_iter1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run0(input string tag, input logic [5:0] wd,
                        input logic [5:0] ew, input logic [2:0] ei,
                        input logic es, input int eit, input int elat);
        int n;
        word   = wd;
        valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        word   = 6'h3F;
        chk({tag, "_busy_ready"}, 32'(o_ready0), 32'd0);
        n = 0;
        while (o_valid0 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(elat));
        chk({tag, "_word"}, 32'(o_word0), 32'(ew));
        chk({tag, "_info"}, 32'(o_info0), 32'(ei));
        chk({tag, "_success"}, 32'(o_success0), 32'(es));
        chk({tag, "_iter"}, 32'(o_iter0), 32'(eit));
        chk({tag, "_done_ready"}, 32'(o_ready0), 32'd0);
    endtask

    task automatic release0(input string tag);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk({tag, "_rel_valid"}, 32'(o_valid0), 32'd0);
        chk({tag, "_rel_ready"}, 32'(o_ready0), 32'd1);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        valid0 = 1'b0;
        valid1 = 1'b0;
        word   = 6'h00;
        h      = HMAT;
        rdy    = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(o_valid0), 32'd0);
        chk("rst_ready", 32'(o_ready0), 32'd1);
        chk("rst_word", 32'(o_word0), 32'd0);
        chk("rst_iter", 32'(o_iter0), 32'd0);
        chk("rst_success", 32'(o_success0), 32'd0);
        rst_n = 1'b1;
        tick();

        run0("clean", 6'h2E, 6'h2E, 3'b101, 1'b1, IT_CLEAN, LAT_CLEAN);
        release0("clean");

        run0("single", 6'h0E, 6'h2E, 3'b101, 1'b1, IT_ONE, LAT_ONE);
        release0("single");

        run0("tie", 6'h2F, 6'h16, 3'b010, 1'b1, IT_TIE, LAT_TIE);
        for (int i = 0; i < 10; i++) begin
            valid0 = 1'b1;
            word   = 6'h15;
            tick();
            chk("hold_valid", 32'(o_valid0), 32'd1);
            chk("hold_word", 32'(o_word0), 32'h16);
            chk("hold_ready", 32'(o_ready0), 32'd0);
        end
        valid0 = 1'b0;
        release0("tie");

        word   = 6'h2F;
        valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        n = 0;
        while (o_valid1 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("limit_latency", 32'(n), 32'd3);
        chk("limit_word", 32'(o_word1), 32'h06);
        chk("limit_info", 32'(o_info1), 32'd0);
        chk("limit_success", 32'(o_success1), 32'd0);
        chk("limit_iter", 32'(o_iter1), 32'd1);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("limit_rel_valid", 32'(o_valid1), 32'd0);
        chk("limit_rel_ready", 32'(o_ready1), 32'd1);

        word   = 6'h0E;
        valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        tick();
        chk("flip_valid", 32'(o_valid0), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("mrst_valid", 32'(o_valid0), 32'd0);
        chk("mrst_ready", 32'(o_ready0), 32'd1);
        chk("mrst_word", 32'(o_word0), 32'd0);
        chk("mrst_info", 32'(o_info0), 32'd0);
        chk("mrst_success", 32'(o_success0), 32'd0);
        chk("mrst_iter", 32'(o_iter0), 32'd0);
        rst_n = 1'b1;
        tick();

        run0("after_rst", 6'h0E, 6'h2E, 3'b101, 1'b1, IT_ONE, LAT_ONE);
        release0("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ldpc_bitflip_decode.md
# ldpc_bitflip_decode

Iterative hard-decision LDPC decoder for the systematic codewords produced by the team's encoder. It accepts an N-bit received word and a flattened parity-check matrix H, and runs Gallager bit-flipping until the syndrome is zero or an iteration limit is reached. It then returns the corrected word, the K info bits, a success flag and the iteration count. It sits on the receive side of the FPGA link, directly downstream of the hard-slicer and upstream of the info-bit sink.

## Interface
- `N`, 6, codeword length.
- `K`, 3, info length; codeword layout is `{info[K-1:0], check[N-K-1:0]}`, so info bit j is at codeword bit `N-K+j`.
- `MAX_ITER`, 8, maximum flip iterations, ≥1.
- `clk` input 1: sole clock, rising edge.
- `i_rst_n` input 1: reset, synchronous, active-low.
- `i_valid` input 1: `i_word`/`i_h` valid.
- `o_ready` output 1: decoder idle, can accept.
- `i_word` input N: received hard-decision word.
- `i_h` input (N-K)*N: H matrix; row r, column c at bit `r*N+c`.
- `o_valid` output 1: result valid, held until taken.
- `i_ready` input 1: downstream takes result.
- `o_word` output N: final (corrected) word.
- `o_info` output K: `o_word[N-1:N-K]`.
- `o_success` output 1: final syndrome is all-zero.
- `o_iter` output `$clog2(MAX_ITER+1)`: flip iterations performed.

## Operation
- States: IDLE, CHECK, FLIP, DONE.
- IDLE: `o_ready=1`. When `i_valid & o_ready`, the decoder captures `i_word` into the working register and `i_h` into the H register, clears the iteration counter, and goes to CHECK.
- CHECK: register syndrome `s[r] = XOR over c of (H[r][c] & w[c])`.
  - If s==0, go to DONE with success.
  - Else if iter==MAX_ITER, go to DONE with failure.
  - Else go to FLIP.
- FLIP: for each bit c, `cnt[c]` = number of rows r with `s[r] & H[r][c]`; width is `$clog2(N-K+1)`.
  - Let m be the maximum cnt.
  - Every bit with `cnt==m` and `m>0` is inverted; all tied bits flip.
  - iter increments; go to CHECK.
- DONE: `o_valid=1`, and `o_word`, `o_info`, `o_success`, `o_iter` are stable.
  - When `i_ready`, go to IDLE; `o_valid` drops and `o_ready` rises on the same edge.
- `o_success=1` means the word is a valid codeword. It does not guarantee the transmitted word; miscorrection is possible.
- Inputs are sampled only at accept. Changes to `i_word`/`i_h` while busy are ignored, and `i_valid` while busy is ignored.
- Reset, at any state including mid-iteration:
  - state goes to IDLE;
  - `o_valid=0`, `o_ready=1`;
  - `o_word=0`, `o_info=0`, `o_success=0`, `o_iter=0`;
  - working registers cleared.

## Timing
- Accept edge is edge 0.
- `o_valid` first seen high after edge `2*iters+1`:
  - error-free word: after edge 1;
  - one flip: after edge 3;
  - limit hit: after edge `2*MAX_ITER+1`.
- There is no bubble beyond the DONE→IDLE edge. The next accept can occur on the first IDLE cycle, so the minimum spacing between accepts is 3 cycles.
- `i_ready` high on the edge that enters DONE has no effect; it is sampled only while in DONE.
- One combinational level per state: syndrome XOR tree in CHECK, count/compare/flip in FLIP.

## Configuration
- `LDPC_DEC_EARLY_EXIT_EN` defined: CHECK exits to DONE as soon as s==0, giving the variable latency above.
- `LDPC_DEC_EARLY_EXIT_EN` undefined: fixed latency.
  - CHECK always goes to FLIP until iter==MAX_ITER.
  - FLIP with s==0 flips nothing, since m=0.
  - `o_valid` appears after edge `2*MAX_ITER+1`.
  - `o_iter=MAX_ITER` always.
  - `o_success` reflects the final syndrome.

## Test plan
All cases use N=6, K=3, `i_h=18'h346A9` (rows 0x29, 0x1A, 0x34), early exit enabled unless noted.
- Clean word: `i_word=6'h2E` → after edge 1, `o_word=2E`, `o_info=3'b101`, success=1, iter=0.
- Single info error: `i_word=6'h0E` (bit 5 flipped) → FLIP inverts bit 5 only → after edge 3, `o_word=2E`, info=101, success=1, iter=1.
- Tie flip/miscorrection: `i_word=6'h2F` → iteration 1 flips bits 0, 3, 5 (→06); iteration 2 flips bit 4 (→16) → after edge 5, `o_word=16`, info=010, success=1, iter=2.
- Limit: `MAX_ITER=1`, `i_word=6'h2F` → after edge 3, `o_word=06`, success=0, iter=1.
- Handshake and reset:
  - With `i_ready=0`, DONE holds `o_valid` and outputs for 10 cycles; `i_valid` pulses are ignored and `o_ready=0`.
  - `i_ready=1` returns to IDLE in 1 edge.
  - Dropping `i_rst_n` during FLIP → next edge all outputs 0, `o_ready=1`.
- Macro undefined, `MAX_ITER=8`, `i_word=6'h2E` → `o_valid` after edge 17, iter=8, `o_word=2E`, success=1.
